fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_fetch_stage.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage with a one-entry skid buffer.
// A three-state FSM (RUN / WAIT / HALT) issues requests to instruction memory
// and writes the returned instructions into the IF/ID register.
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   stall             hold the PC and the IF/ID outputs
//   redirect,
//   redirect_pc       taken branch/jump: flush and refetch from redirect_pc
//   halt_in           HALT decoded downstream: stop fetching
//   imem_en/addr      instruction-memory request (combinational from state)
//   imem_data/done    returned instruction and its valid strobe
//   instr, pc_plus2,
//   valid             IF/ID register contents
//   align_err_i       the fetch address was odd (sticky until HALT is left)
//   halted            fetch has stopped
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt_in,
  output logic        imem_en,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  output logic [15:0] instr,
  output logic [15:0] pc_plus2,
  output logic        valid,
  output logic        align_err_i,
  output logic        halted
);

  localparam int unsigned XLEN = 16;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_req_addr;
  logic [XLEN-1:0]   r_instr;
  logic [XLEN-1:0]   r_pc_plus2;
  logic              r_valid;
  logic              r_align_err;
  logic              r_halted;
  logic              r_skid_vld;
  logic [XLEN-1:0]   r_skid_instr;
  logic [XLEN-1:0]   r_skid_pc2;
  logic              r_squash;
  logic              r_halt_pend;

  logic              w_en;
  logic              w_issue;
  logic              w_capture;
  logic              w_to_skid;
  logic              w_drain;
  logic              w_misalign;
  logic              w_enter_halt;
  logic              w_squash_nxt;
  logic              w_halt_pend_nxt;
  logic [XLEN-1:0]   w_pc_inc;

  assign w_pc_inc = r_pc + XLEN'(2);

  // Request port: new requests come from RUN, WAIT holds the original address
  // even after a redirect has moved the PC.
  assign imem_en     = rst & w_en;
  assign imem_addr   = (r_state == S_WAIT) ? r_req_addr : r_pc;
  assign instr       = r_instr;
  assign pc_plus2    = r_pc_plus2;
  assign valid       = r_valid;
  assign align_err_i = r_align_err;
  assign halted      = r_halted;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_RUN;
    else      r_state <= w_next_state;
  end

  // Next state and datapath controls; priority redirect > halt_in > stall > fetch
  always_comb begin
    w_next_state    = r_state;
    w_en            = 1'b0;
    w_issue         = 1'b0;
    w_capture       = 1'b0;
    w_to_skid       = 1'b0;
    w_drain         = 1'b0;
    w_misalign      = 1'b0;
    w_enter_halt    = 1'b0;
    w_squash_nxt    = r_squash;
    w_halt_pend_nxt = r_halt_pend;
    unique case (r_state)
      S_RUN: begin
        if (redirect) begin
          w_next_state = S_RUN;
        end else if (halt_in) begin
          w_next_state = S_HALT;
          w_enter_halt = 1'b1;
        end else if (stall) begin
          w_next_state = S_RUN;
        end else if (r_skid_vld) begin
          // Buffered instruction goes out first; the port stays idle this cycle.
          w_drain = 1'b1;
        end else if (r_pc[0]) begin
          w_misalign   = 1'b1;
          w_next_state = S_HALT;
        end else begin
          w_en    = 1'b1;
          w_issue = 1'b1;
          if (imem_done) w_capture    = 1'b1;
          else           w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        w_en = 1'b1;
        if (redirect) begin
          // Response still owed for the old address: drop it when it arrives.
          w_halt_pend_nxt = 1'b0;
          if (imem_done) begin
            w_next_state = S_RUN;
            w_squash_nxt = 1'b0;
          end else begin
            w_squash_nxt = 1'b1;
          end
        end else if (imem_done) begin
          w_squash_nxt    = 1'b0;
          w_halt_pend_nxt = 1'b0;
          if (halt_in || r_halt_pend) begin
            w_next_state = S_HALT;
            w_enter_halt = 1'b1;
          end else begin
            w_next_state = S_RUN;
            if (!r_squash) begin
              if (stall) w_to_skid = 1'b1;
              else       w_capture = 1'b1;
            end
          end
        end else if (halt_in) begin
          w_halt_pend_nxt = 1'b1;
        end
      end
      S_HALT: begin
        if (redirect) w_next_state = S_RUN;
      end
      default: w_next_state = S_RUN;
    endcase
  end

  // PC, IF/ID register, skid buffer and side flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc         <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_instr      <= NOP_INSTR;
      r_pc_plus2   <= '0;
      r_valid      <= 1'b0;
      r_align_err  <= 1'b0;
      r_halted     <= 1'b0;
      r_skid_vld   <= 1'b0;
      r_skid_instr <= NOP_INSTR;
      r_skid_pc2   <= '0;
      r_squash     <= 1'b0;
      r_halt_pend  <= 1'b0;
    end else begin
      r_squash    <= w_squash_nxt;
      r_halt_pend <= w_halt_pend_nxt;
      if (w_issue) r_req_addr <= r_pc;
      if (redirect) begin
        r_pc        <= redirect_pc;
        r_instr     <= NOP_INSTR;
        r_valid     <= 1'b0;
        r_skid_vld  <= 1'b0;
        r_align_err <= 1'b0;
        r_halted    <= 1'b0;
      end else begin
        if (w_capture) begin
          r_instr    <= imem_data;
          r_pc_plus2 <= w_pc_inc;
          r_valid    <= 1'b1;
          r_pc       <= w_pc_inc;
        end
        if (w_to_skid) begin
          r_skid_vld   <= 1'b1;
          r_skid_instr <= imem_data;
          r_skid_pc2   <= w_pc_inc;
          r_pc         <= w_pc_inc;
        end
        if (w_drain) begin
          r_instr    <= r_skid_instr;
          r_pc_plus2 <= r_skid_pc2;
          r_valid    <= 1'b1;
          r_skid_vld <= 1'b0;
        end
        if (w_misalign) begin
          r_instr     <= NOP_INSTR;
          r_valid     <= 1'b1;
          r_align_err <= 1'b1;
          r_halted    <= 1'b1;
        end
        if (w_enter_halt) begin
          r_halted   <= 1'b1;
          r_skid_vld <= 1'b0;
        end
        // Once halted, nothing further is presented to decode.
        if (r_state == S_HALT) r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a
// transaction-level model (memory image, epoch-tagged requests, skid queue).
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, halt_in, imem_done;
  logic [15:0] redirect_pc, imem_data;
  logic        imem_en, valid, align_err_i, halted;
  logic [15:0] imem_addr, instr, pc_plus2;

  fetch_stage #(.RESET_PC(16'h0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt_in(halt_in), .imem_en(imem_en),
    .imem_addr(imem_addr), .imem_data(imem_data), .imem_done(imem_done),
    .instr(instr), .pc_plus2(pc_plus2), .valid(valid),
    .align_err_i(align_err_i), .halted(halted)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [256];
  int          lat, wcnt, req_ep, epoch;
  bit          req_open, mdl_on, new_req, en_seen;
  logic [15:0] req_addr, addr_seen;
  logic [15:0] exp_instr, exp_pc2, exp_pc;
  logic        exp_valid;
  logic [31:0] pend_q [$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: memory answers at the negedge, model advances, outputs sampled after posedge.
  task automatic cyc();
    logic        dn;
    logic [15:0] dat;
    @(negedge clk);
    dn        = 1'b0;
    dat       = 16'($urandom);
    new_req   = 1'b0;
    en_seen   = imem_en;
    addr_seen = imem_addr;
    if (!rst) begin
      req_open = 1'b0;
      wcnt     = 0;
    end else if (imem_en) begin
      if (!req_open) begin
        req_open = 1'b1;
        req_addr = imem_addr;
        req_ep   = epoch;
        wcnt     = 0;
        new_req  = 1'b1;
        chk("req_during_stall", 16'(stall), 16'd0);
        if (mdl_on) chk("req_addr", imem_addr, exp_pc);
      end else begin
        chk("addr_held", imem_addr, req_addr);
      end
      if (wcnt >= lat) begin
        dn       = 1'b1;
        dat      = mem[req_addr[8:1]];
        req_open = 1'b0;
      end else begin
        wcnt++;
      end
    end
    imem_done = dn;
    imem_data = dat;
    if (mdl_on) begin
      if (pend_q.size() != 0) chk("en_with_skid", 16'(imem_en), 16'd0);
      if (redirect) begin
        exp_pc    = redirect_pc;
        exp_valid = 1'b0;
        exp_instr = NOP;
        pend_q.delete();
      end else begin
        if (pend_q.size() != 0 && !stall) begin
          {exp_instr, exp_pc2} = pend_q.pop_front();
          exp_valid = 1'b1;
        end
        if (dn && req_ep == epoch) begin
          if (stall) pend_q.push_back({dat, 16'(req_addr + 16'd2)});
          else begin
            exp_instr = dat;
            exp_pc2   = req_addr + 16'd2;
            exp_valid = 1'b1;
          end
          exp_pc = req_addr + 16'd2;
        end
      end
    end
    if (redirect) epoch++;
    @(posedge clk);
    #1;
    if (mdl_on) begin
      chk("instr", instr, exp_instr);
      chk("pc_plus2", pc_plus2, exp_pc2);
      chk("valid", 16'(valid), 16'(exp_valid));
    end
  endtask

  // Stall until no request is outstanding (bounded).
  task automatic idle();
    int n;
    stall    = 1'b1;
    redirect = 1'b0;
    lat      = 0;
    n        = 0;
    do begin
      cyc();
      n++;
    end while (req_open && n < 8);
    chk("idle_timeout", 16'(req_open), 16'd0);
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; halt_in = 1'b0;
    imem_done = 1'b0; imem_data = '0;
    lat = 0; wcnt = 0; req_open = 1'b0; epoch = 0; req_ep = 0; mdl_on = 1'b0;
    req_addr = '0; addr_seen = '0; new_req = 1'b0; en_seen = 1'b0;
    foreach (mem[i]) mem[i] = 16'($urandom);
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'hABCD;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", 16'(imem_en), 16'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc2", pc_plus2, 16'h0000);
    chk("rst_valid", 16'(valid), 16'd0);
    chk("rst_align", 16'(align_err_i), 16'd0);
    chk("rst_halted", 16'(halted), 16'd0);

    // Zero-wait sequential fetch
    exp_pc = 16'h0000; exp_instr = NOP; exp_pc2 = 16'h0000; exp_valid = 1'b0;
    mdl_on = 1'b1;
    rst    = 1'b1;
    cyc();
    chk("first_req", 16'(new_req), 16'd1);
    chk("first_addr", addr_seen, 16'h0000);
    chk("seq1_instr", instr, 16'h1111);
    chk("seq1_pc2", pc_plus2, 16'h0002);
    cyc();
    chk("seq2_instr", instr, 16'h2222);
    chk("seq2_pc2", pc_plus2, 16'h0004);

    // Three-cycle memory latency at pc=4
    lat = 3;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("dly_en", 16'(en_seen), 16'd1);
      chk("dly_addr", addr_seen, 16'h0004);
      chk("dly_instr", instr, 16'h2222);
    end
    cyc();
    chk("dly_addr_last", addr_seen, 16'h0004);
    chk("dly_done_instr", instr, 16'h3333);
    chk("dly_done_pc2", pc_plus2, 16'h0006);

    // Response lands during a 2-cycle stall
    lat = 2;
    cyc();
    stall = 1'b1;
    cyc();
    chk("stall_frz_instr", instr, 16'h3333);
    cyc();
    chk("stall_frz_instr2", instr, 16'h3333);
    chk("stall_frz_pc2", pc_plus2, 16'h0006);
    stall = 1'b0;
    lat   = 0;
    cyc();
    chk("skid_no_en", 16'(en_seen), 16'd0);
    chk("skid_instr", instr, 16'hABCD);
    chk("skid_pc2", pc_plus2, 16'h0008);

    // Redirect while waiting at pc=8
    lat = 3;
    cyc();
    chk("wait8_addr", addr_seen, 16'h0008);
    redirect = 1'b1; redirect_pc = 16'h0040;
    cyc();
    chk("redir_valid", 16'(valid), 16'd0);
    chk("redir_instr", instr, NOP);
    redirect = 1'b0;
    cyc();
    chk("squash_addr_held", addr_seen, 16'h0008);
    cyc();
    chk("squash_valid", 16'(valid), 16'd0);
    lat = 0;
    cyc();
    chk("redir_new_req", 16'(new_req), 16'd1);
    chk("redir_new_addr", addr_seen, 16'h0040);
    chk("redir_instr_new", instr, mem[8'h20]);
    chk("redir_pc2_new", pc_plus2, 16'h0042);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = 16'($urandom_range(0, 255) * 2);
      if (!req_open) lat = $urandom_range(0, 3);
      cyc();
    end

    // PC wrap at 16'hFFFE
    idle();
    redirect = 1'b1; redirect_pc = 16'hFFFC;
    cyc();
    redirect = 1'b0; stall = 1'b0; lat = 0;
    cyc();
    chk("wrap_pc2_a", pc_plus2, 16'hFFFE);
    cyc();
    chk("wrap_pc2_b", pc_plus2, 16'h0000);
    chk("wrap_instr", instr, mem[8'hFF]);
    cyc();
    chk("wrap_next_addr", addr_seen, 16'h0000);

    // Misaligned redirect target
    idle();
    mdl_on = 1'b0;
    redirect = 1'b1; redirect_pc = 16'h0041;
    cyc();
    chk("mis_redir_valid", 16'(valid), 16'd0);
    redirect = 1'b0; stall = 1'b0;
    cyc();
    chk("mis_no_en", 16'(en_seen), 16'd0);
    chk("mis_instr", instr, NOP);
    chk("mis_valid", 16'(valid), 16'd1);
    chk("mis_align", 16'(align_err_i), 16'd1);
    chk("mis_halted", 16'(halted), 16'd1);
    cyc();
    chk("halt_no_en", 16'(en_seen), 16'd0);
    chk("halt_valid", 16'(valid), 16'd0);
    chk("halt_sticky", 16'(halted), 16'd1);

    // Leave HALT by redirect, then halt_in while waiting at 0x10
    redirect = 1'b1; redirect_pc = 16'h0010; lat = 2;
    cyc();
    chk("unhalt_align", 16'(align_err_i), 16'd0);
    chk("unhalt_halted", 16'(halted), 16'd0);
    redirect = 1'b0;
    cyc();
    chk("h_req", 16'(new_req), 16'd1);
    chk("h_addr", addr_seen, 16'h0010);
    halt_in = 1'b1;
    cyc();
    chk("h_pending", 16'(halted), 16'd0);
    halt_in = 1'b0;
    cyc();
    chk("h_halted", 16'(halted), 16'd1);
    chk("h_discard", instr, NOP);
    chk("h_valid", 16'(valid), 16'd0);
    cyc();
    chk("h_no_en", 16'(en_seen), 16'd0);

    // Reset pulsed mid-WAIT
    redirect = 1'b1; redirect_pc = 16'h0020; lat = 20;
    cyc();
    redirect = 1'b0;
    cyc();
    chk("r_req_addr", addr_seen, 16'h0020);
    cyc();
    cyc();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_en", 16'(imem_en), 16'd0);
    chk("arst_instr", instr, NOP);
    chk("arst_pc2", pc_plus2, 16'h0000);
    chk("arst_valid", 16'(valid), 16'd0);
    chk("arst_halted", 16'(halted), 16'd0);
    chk("arst_align", 16'(align_err_i), 16'd0);
    cyc();
    chk("arst_en_hold", 16'(en_seen), 16'd0);
    rst = 1'b1; lat = 0;
    cyc();
    chk("post_rst_req", 16'(new_req), 16'd1);
    chk("post_rst_addr", addr_seen, 16'h0000);
    chk("post_rst_instr", instr, 16'h1111);
    chk("post_rst_pc2", pc_plus2, 16'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
